multicore: RTL and testbench

MULTICORE -- requirements
Module: multicore

---
 rtl/multicore_pkg.sv | 29 ++
 rtl/taylor_core.sv | 71 +++++++
 rtl/multicore.sv | 100 ++++++++++
 tb/tb_multicore.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared definitions for the multicore Taylor-series evaluator.
// Holds the core count, the datapath widths, the 4-bit status codes used on
// the req_in/out_en ports, and the output saturation helper.
package multicore_pkg;

    localparam int NCORES = 30;
    localparam int IN_W   = 19;
    localparam int OUT_W  = 28;
    localparam int ACC_W  = 48;
    localparam int SLOT_W = $clog2(NCORES);

    // Status codes driven on req_in/out_en; codes 2..15 are never produced.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ACTIVE = 4'd1
    } status_t;

    // Clamp a wide accumulator to the signed OUT_W-bit result range.
    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        logic signed [OUT_W-1:0] r;
        if (v > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
        else                  r = v[OUT_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/taylor_core.sv
// One evaluation core: captures a sample when its slot is active, runs a
// 3-stage Horner pipeline y = ((C3*x + C2)*x + C1)*x + C0 in Q(FRAC) and
// presents the saturated result with a one-cycle valid pulse.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   cap       - capture `in` at this edge
//   in        - signed sample
//   io_out    - registered, saturated result (held between results)
//   out_en    - ST_ACTIVE for the single cycle io_out is freshly valid
module taylor_core
    import multicore_pkg::*;
#(
    parameter int C3   = 43,
    parameter int C2   = 128,
    parameter int C1   = 256,
    parameter int C0   = 256,
    parameter int FRAC = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap,
    input  logic signed [IN_W-1:0]  in,
    output logic signed [OUT_W-1:0] io_out,
    output logic [3:0]              out_en
);

    localparam logic signed [ACC_W-1:0] K3 = ACC_W'(C3);
    localparam logic signed [ACC_W-1:0] K2 = ACC_W'(C2);
    localparam logic signed [ACC_W-1:0] K1 = ACC_W'(C1);
    localparam logic signed [ACC_W-1:0] K0 = ACC_W'(C0);

    logic signed [IN_W-1:0]  x;
    logic signed [ACC_W-1:0] x_ext, a1, a2, a1_next, a2_next, y_next;
    logic                    v_x, v_a1, v_a2;

    // NOTE: combinational logic uses blocking assignments; every output is
    // assigned on every pass so no latch can be inferred.
    always_comb begin
        x_ext   = {{(ACC_W-IN_W){x[IN_W-1]}}, x};
        a1_next = ((K3 * x_ext) >>> FRAC) + K2;
        a2_next = ((a1 * x_ext) >>> FRAC) + K1;
        y_next  = ((a2 * x_ext) >>> FRAC) + K0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_x    <= 1'b0;
            v_a1   <= 1'b0;
            v_a2   <= 1'b0;
            io_out <= '0;
            out_en <= ST_IDLE;
        end else begin
            v_x    <= cap;
            v_a1   <= v_x;
            v_a2   <= v_a1;
            out_en <= v_a2 ? ST_ACTIVE : ST_IDLE;
            if (v_a2) io_out <= saturate(y_next);
        end
    end

    // NOTE: datapath registers carry no reset; the valid chain above is what
    // discards in-flight work, so stale data here is never observed.
    always_ff @(posedge clk) begin
        if (cap)  x  <= in;
        if (v_x)  a1 <= a1_next;
        if (v_a1) a2 <= a2_next;
    end

endmodule

// File: rtl/multicore.sv
// Time-interleaved polynomial evaluator: a slot counter hands the shared
// input to one of 30 taylor_core instances per cycle, giving one sample in
// and one result out per cycle in steady state.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in                    - signed 19-bit sample for the core holding the slot
//   io_out0..io_out29     - signed 28-bit registered result of core k
//   req_in0..req_in29     - 4'd1 when core k captures `in` this cycle
//   out_en0..out_en29     - 4'd1 for the single cycle io_outk is fresh
module multicore #(
    parameter int NCORES = multicore_pkg::NCORES,
    parameter int C3     = 43,
    parameter int C2     = 128,
    parameter int C1     = 256,
    parameter int C0     = 256,
    parameter int FRAC   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic signed [multicore_pkg::IN_W-1:0] in,
    output logic signed [multicore_pkg::OUT_W-1:0]
        io_out0,  io_out1,  io_out2,  io_out3,  io_out4,  io_out5,  io_out6,  io_out7,
        io_out8,  io_out9,  io_out10, io_out11, io_out12, io_out13, io_out14, io_out15,
        io_out16, io_out17, io_out18, io_out19, io_out20, io_out21, io_out22, io_out23,
        io_out24, io_out25, io_out26, io_out27, io_out28, io_out29,
    output logic [3:0]
        req_in0,  req_in1,  req_in2,  req_in3,  req_in4,  req_in5,  req_in6,  req_in7,
        req_in8,  req_in9,  req_in10, req_in11, req_in12, req_in13, req_in14, req_in15,
        req_in16, req_in17, req_in18, req_in19, req_in20, req_in21, req_in22, req_in23,
        req_in24, req_in25, req_in26, req_in27, req_in28, req_in29,
    output logic [3:0]
        out_en0,  out_en1,  out_en2,  out_en3,  out_en4,  out_en5,  out_en6,  out_en7,
        out_en8,  out_en9,  out_en10, out_en11, out_en12, out_en13, out_en14, out_en15,
        out_en16, out_en17, out_en18, out_en19, out_en20, out_en21, out_en22, out_en23,
        out_en24, out_en25, out_en26, out_en27, out_en28, out_en29
);

    import multicore_pkg::*;

    logic [SLOT_W-1:0]       slot;
    logic signed [OUT_W-1:0] outs [NCORES];
    logic [3:0]              reqs [NCORES];
    logic [3:0]              ens  [NCORES];

    always_ff @(posedge clk) begin
        if (rst)                               slot <= '0;
        else if (slot == SLOT_W'(NCORES - 1))  slot <= '0;
        else                                   slot <= slot + SLOT_W'(1);
    end

    for (genvar k = 0; k < NCORES; k++) begin : g_core
        // Gated by rst so no core claims the slot while reset is held.
        assign reqs[k] = (!rst && slot == SLOT_W'(k)) ? ST_ACTIVE : ST_IDLE;

        taylor_core #(
            .C3(C3), .C2(C2), .C1(C1), .C0(C0), .FRAC(FRAC)
        ) u_core (
            .clk    (clk),
            .rst    (rst),
            .cap    (reqs[k] == ST_ACTIVE),
            .in     (in),
            .io_out (outs[k]),
            .out_en (ens[k])
        );
    end

    assign io_out0  = outs[0];  assign io_out1  = outs[1];  assign io_out2  = outs[2];
    assign io_out3  = outs[3];  assign io_out4  = outs[4];  assign io_out5  = outs[5];
    assign io_out6  = outs[6];  assign io_out7  = outs[7];  assign io_out8  = outs[8];
    assign io_out9  = outs[9];  assign io_out10 = outs[10]; assign io_out11 = outs[11];
    assign io_out12 = outs[12]; assign io_out13 = outs[13]; assign io_out14 = outs[14];
    assign io_out15 = outs[15]; assign io_out16 = outs[16]; assign io_out17 = outs[17];
    assign io_out18 = outs[18]; assign io_out19 = outs[19]; assign io_out20 = outs[20];
    assign io_out21 = outs[21]; assign io_out22 = outs[22]; assign io_out23 = outs[23];
    assign io_out24 = outs[24]; assign io_out25 = outs[25]; assign io_out26 = outs[26];
    assign io_out27 = outs[27]; assign io_out28 = outs[28]; assign io_out29 = outs[29];

    assign req_in0  = reqs[0];  assign req_in1  = reqs[1];  assign req_in2  = reqs[2];
    assign req_in3  = reqs[3];  assign req_in4  = reqs[4];  assign req_in5  = reqs[5];
    assign req_in6  = reqs[6];  assign req_in7  = reqs[7];  assign req_in8  = reqs[8];
    assign req_in9  = reqs[9];  assign req_in10 = reqs[10]; assign req_in11 = reqs[11];
    assign req_in12 = reqs[12]; assign req_in13 = reqs[13]; assign req_in14 = reqs[14];
    assign req_in15 = reqs[15]; assign req_in16 = reqs[16]; assign req_in17 = reqs[17];
    assign req_in18 = reqs[18]; assign req_in19 = reqs[19]; assign req_in20 = reqs[20];
    assign req_in21 = reqs[21]; assign req_in22 = reqs[22]; assign req_in23 = reqs[23];
    assign req_in24 = reqs[24]; assign req_in25 = reqs[25]; assign req_in26 = reqs[26];
    assign req_in27 = reqs[27]; assign req_in28 = reqs[28]; assign req_in29 = reqs[29];

    assign out_en0  = ens[0];   assign out_en1  = ens[1];   assign out_en2  = ens[2];
    assign out_en3  = ens[3];   assign out_en4  = ens[4];   assign out_en5  = ens[5];
    assign out_en6  = ens[6];   assign out_en7  = ens[7];   assign out_en8  = ens[8];
    assign out_en9  = ens[9];   assign out_en10 = ens[10];  assign out_en11 = ens[11];
    assign out_en12 = ens[12];  assign out_en13 = ens[13];  assign out_en14 = ens[14];
    assign out_en15 = ens[15];  assign out_en16 = ens[16];  assign out_en17 = ens[17];
    assign out_en18 = ens[18];  assign out_en19 = ens[19];  assign out_en20 = ens[20];
    assign out_en21 = ens[21];  assign out_en22 = ens[22];  assign out_en23 = ens[23];
    assign out_en24 = ens[24];  assign out_en25 = ens[25];  assign out_en26 = ens[26];
    assign out_en27 = ens[27];  assign out_en28 = ens[28];  assign out_en29 = ens[29];

endmodule

// File: tb/tb_multicore.sv
// Self-checking bench for multicore: reset behaviour, slot rotation,
// directed Horner results (zero, signed, saturating), a 90-sample stream
// against an independent reference, and reset during computation.
module tb_multicore;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [18:0]  in  = '0;
    logic signed [27:0]  io_out [30];
    logic [3:0]          req_in [30];
    logic [3:0]          out_en [30];

    int    n_pass  = 0;
    int    n_total = 0;
    longint xs   [90];
    longint want [90];

    always #5 clk = ~clk;

    multicore dut (
        .clk(clk), .rst(rst), .in(in),
        .io_out0(io_out[0]),   .io_out1(io_out[1]),   .io_out2(io_out[2]),   .io_out3(io_out[3]),
        .io_out4(io_out[4]),   .io_out5(io_out[5]),   .io_out6(io_out[6]),   .io_out7(io_out[7]),
        .io_out8(io_out[8]),   .io_out9(io_out[9]),   .io_out10(io_out[10]), .io_out11(io_out[11]),
        .io_out12(io_out[12]), .io_out13(io_out[13]), .io_out14(io_out[14]), .io_out15(io_out[15]),
        .io_out16(io_out[16]), .io_out17(io_out[17]), .io_out18(io_out[18]), .io_out19(io_out[19]),
        .io_out20(io_out[20]), .io_out21(io_out[21]), .io_out22(io_out[22]), .io_out23(io_out[23]),
        .io_out24(io_out[24]), .io_out25(io_out[25]), .io_out26(io_out[26]), .io_out27(io_out[27]),
        .io_out28(io_out[28]), .io_out29(io_out[29]),
        .req_in0(req_in[0]),   .req_in1(req_in[1]),   .req_in2(req_in[2]),   .req_in3(req_in[3]),
        .req_in4(req_in[4]),   .req_in5(req_in[5]),   .req_in6(req_in[6]),   .req_in7(req_in[7]),
        .req_in8(req_in[8]),   .req_in9(req_in[9]),   .req_in10(req_in[10]), .req_in11(req_in[11]),
        .req_in12(req_in[12]), .req_in13(req_in[13]), .req_in14(req_in[14]), .req_in15(req_in[15]),
        .req_in16(req_in[16]), .req_in17(req_in[17]), .req_in18(req_in[18]), .req_in19(req_in[19]),
        .req_in20(req_in[20]), .req_in21(req_in[21]), .req_in22(req_in[22]), .req_in23(req_in[23]),
        .req_in24(req_in[24]), .req_in25(req_in[25]), .req_in26(req_in[26]), .req_in27(req_in[27]),
        .req_in28(req_in[28]), .req_in29(req_in[29]),
        .out_en0(out_en[0]),   .out_en1(out_en[1]),   .out_en2(out_en[2]),   .out_en3(out_en[3]),
        .out_en4(out_en[4]),   .out_en5(out_en[5]),   .out_en6(out_en[6]),   .out_en7(out_en[7]),
        .out_en8(out_en[8]),   .out_en9(out_en[9]),   .out_en10(out_en[10]), .out_en11(out_en[11]),
        .out_en12(out_en[12]), .out_en13(out_en[13]), .out_en14(out_en[14]), .out_en15(out_en[15]),
        .out_en16(out_en[16]), .out_en17(out_en[17]), .out_en18(out_en[18]), .out_en19(out_en[19]),
        .out_en20(out_en[20]), .out_en21(out_en[21]), .out_en22(out_en[22]), .out_en23(out_en[23]),
        .out_en24(out_en[24]), .out_en25(out_en[25]), .out_en26(out_en[26]), .out_en27(out_en[27]),
        .out_en28(out_en[28]), .out_en29(out_en[29])
    );

    task automatic check(input string tag, input longint got, input longint exp_v);
        n_total++;
        if (got == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp_v);
    endtask

    // Reference for default coefficients 43/128/256/256, FRAC = 8.
    function automatic longint horner(input longint x);
        longint a;
        a = ((43 * x) >>> 8) + 128;
        a = ((a * x) >>> 8) + 256;
        a = ((a * x) >>> 8) + 256;
        if (a > 134217727)       a = 134217727;
        else if (a < -134217728) a = -134217728;
        return a;
    endfunction

    function automatic int sum4(input logic [3:0] v [30]);
        int s = 0;
        for (int i = 0; i < 30; i++) s += int'(v[i]);
        return s;
    endfunction

    initial begin
        longint hand [5];
        hand = '{256, 683, 85, 134217727, -134217728};
        xs[0] = 0; xs[1] = 256; xs[2] = -256; xs[3] = 262143; xs[4] = -262144;
        for (int c = 5; c < 90; c++) begin
            if (c % 3 == 0) xs[c] = longint'((c * 1237) % 2048) - 1024;
            else            xs[c] = longint'((c * 40503 + 12345) % 524288) - 262144;
        end
        for (int c = 0; c < 90; c++) want[c] = horner(xs[c]);

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_req_sum_%0d", i), sum4(req_in), 0);
            check($sformatf("rst_en_sum_%0d", i), sum4(out_en), 0);
            check($sformatf("rst_io_out0_%0d", i), io_out[0], 0);
            check($sformatf("rst_io_out29_%0d", i), io_out[29], 0);
        end
        rst = 1'b0;

        // Cycle c starts at this negedge; slot c%30 captures xs[c].
        for (int c = 0; c < 97; c++) begin
            if (c < 90)       in = 19'(xs[c]);
            else if (c == 95) in = 19'sd1000;
            else              in = '0;
            #1;
            check($sformatf("req_in%0d_c%0d", c % 30, c), req_in[c % 30], 1);
            check($sformatf("req_sum_c%0d", c), sum4(req_in), 1);
            if (c < 4) begin
                check($sformatf("no_en_c%0d", c), sum4(out_en), 0);
            end else if (c < 94) begin
                check($sformatf("out_en%0d_c%0d", (c - 4) % 30, c), out_en[(c - 4) % 30], 1);
                check($sformatf("en_sum_c%0d", c), sum4(out_en), 1);
                check($sformatf("io_out%0d_c%0d", (c - 4) % 30, c), io_out[(c - 4) % 30], want[c - 4]);
                if (c < 9)
                    check($sformatf("hand_io_out%0d", c - 4), io_out[c - 4], hand[c - 4]);
            end else begin
                check($sformatf("idle_out_en5_c%0d", c), out_en[5], 0);
            end
            if (c >= 5 && c < 95)
                check($sformatf("hold_io_out%0d_c%0d", (c - 5) % 30, c), io_out[(c - 5) % 30], want[c - 5]);
            @(negedge clk);
        end

        // Cycle 97: core 5 captured at 95; reset lands two cycles later.
        rst = 1'b1;
        in  = '0;
        #1;
        check("midrst_req_sum", sum4(req_in), 0);
        @(negedge clk);
        check("midrst_en_sum", sum4(out_en), 0);
        check("midrst_io_out5", io_out[5], 0);
        check("midrst_io_out3", io_out[3], 0);
        rst = 1'b0;

        for (int c = 0; c < 7; c++) begin
            #1;
            if (c == 0) begin
                check("restart_req_in0", req_in[0], 1);
                check("restart_req_sum", sum4(req_in), 1);
            end
            check($sformatf("restart_out_en5_c%0d", c), out_en[5], 0);
            check($sformatf("restart_io_out5_c%0d", c), io_out[5], 0);
            if (c == 4) begin
                check("restart_out_en0", out_en[0], 1);
                check("restart_io_out0", io_out[0], 256);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
